// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: control-bundle bit positions,
// handshake FSM states, default widths and an alignment helper.
package mem_access_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  // WB control bundle {reg_write, mem_to_reg}
  localparam int unsigned WB_REGW = 1;
  localparam int unsigned WB_M2R  = 0;

  // MEM control bundle {branch, mem_read, mem_write}
  localparam int unsigned MEM_BR = 2;
  localparam int unsigned MEM_RD = 1;
  localparam int unsigned MEM_WR = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  // Word accesses only: the two byte-offset bits must be zero.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
//   master (MEM stage): drives req, we, addr, wdata; receives rdata, ack.
//   slave  (memory)   : receives req, we, addr, wdata; drives rdata, ack.
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_access_stage_dmem_handshake_fsm.sv
// Data-memory handshake controller: issues one request per aligned memory
// op, waits for ack with a bounded timeout, captures read data and keeps a
// sticky error flag (misalignment or timeout). State updates on falling edge.
//   in : clk, rst (async active-low), mem_op, is_write, aligned, ack, rdata
//   out: state, req, we, rdata_q, err
module mem_access_stage_dmem_handshake_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_op,
  input  logic              is_write,
  input  logic              aligned,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata,
  output mem_state_e        state,
  output logic              req,
  output logic              we,
  output logic [DATA_W-1:0] rdata_q,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // State and datapath registers
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; ack on the expiry edge takes priority over timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            we_d    = is_write;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          data_d  = we_q ? '0 : rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Inputs advance on this edge; the next instruction is not issued here
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state   = state_q;
  assign req     = req_q;
  assign we      = we_q;
  assign rdata_q = data_q;
  assign err     = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the EX/MEM bundle, performs loads/stores over
// the dmem bus (stalling upstream while pending), resolves branches, drives
// forwarding taps and registers the MEM/WB bundle on the falling edge.
//   in : clk, rst (async active-low), inWB, inMEM, inPCJump, inALUResult,
//        inALUZero, inRegB, inRegF_wreg
//   bus: dmem (master side of mem_access_stage_if)
//   out: outStall, outPCSrc, outPCBranch, MEM_AluResult, MEM_rd, MEM_regF_wr,
//        outWB, outReadData, outALUResult, outRegF_wreg, outMemErr
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        inWB,
  input  logic [2:0]        inMEM,
  input  logic [DATA_W-1:0] inPCJump,
  input  logic [DATA_W-1:0] inALUResult,
  input  logic              inALUZero,
  input  logic [DATA_W-1:0] inRegB,
  input  logic [REG_W-1:0]  inRegF_wreg,
  mem_access_stage_if.master dmem,
  output logic              outStall,
  output logic              outPCSrc,
  output logic [DATA_W-1:0] outPCBranch,
  output logic [DATA_W-1:0] MEM_AluResult,
  output logic [REG_W-1:0]  MEM_rd,
  output logic              MEM_regF_wr,
  output logic [1:0]        outWB,
  output logic [DATA_W-1:0] outReadData,
  output logic [DATA_W-1:0] outALUResult,
  output logic [REG_W-1:0]  outRegF_wreg,
  output logic              outMemErr
);

  logic              mem_op;
  logic              aligned;
  mem_state_e        state;
  logic              fsm_req;
  logic              fsm_we;
  logic              fsm_err;
  logic [DATA_W-1:0] fsm_rdata;

  // Read+write together is treated as a write
  assign mem_op  = inMEM[MEM_RD] | inMEM[MEM_WR];
  assign aligned = is_word_aligned(inALUResult[1:0]);

  mem_access_stage_dmem_handshake_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_op   (mem_op),
    .is_write (inMEM[MEM_WR]),
    .aligned  (aligned),
    .ack      (dmem.ack),
    .rdata    (dmem.rdata),
    .state    (state),
    .req      (fsm_req),
    .we       (fsm_we),
    .rdata_q  (fsm_rdata),
    .err      (fsm_err)
  );

  // Bus drive: address/data come straight from the held EX/MEM inputs
  assign dmem.req   = fsm_req;
  assign dmem.we    = fsm_we;
  assign dmem.addr  = inALUResult;
  assign dmem.wdata = inRegB;

  // Branch resolution and forwarding taps
  assign outPCSrc      = inMEM[MEM_BR] & inALUZero;
  assign outPCBranch   = inPCJump;
  assign MEM_AluResult = inALUResult;
  assign MEM_rd        = inRegF_wreg;
  assign MEM_regF_wr   = inWB[WB_REGW];

  assign outStall  = ((state == S_IDLE) & mem_op & aligned) | (state == S_WAIT);
  assign outMemErr = fsm_err;

  // MEM/WB register; in IDLE any mem_op (aligned: stalled, misaligned: dropped) bubbles
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      outWB        <= 2'b00;
      outReadData  <= '0;
      outALUResult <= '0;
      outRegF_wreg <= '0;
    end else if (state == S_DONE) begin
      outWB        <= inWB;
      outReadData  <= fsm_rdata;
      outALUResult <= inALUResult;
      outRegF_wreg <= inRegF_wreg;
    end else if (outStall || mem_op) begin
      outWB        <= 2'b00;
      outReadData  <= '0;
      outALUResult <= '0;
      outRegF_wreg <= '0;
    end else begin
      outWB        <= inWB;
      outReadData  <= '0;
      outALUResult <= inALUResult;
      outRegF_wreg <= inRegF_wreg;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized instructions, each predicted from an access-level model
// (stall length from ack latency/timeout, write-back contents, sticky error).
module tb_mem_access_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        inWB;
  logic [2:0]        inMEM;
  logic [DATA_W-1:0] inPCJump;
  logic [DATA_W-1:0] inALUResult;
  logic              inALUZero;
  logic [DATA_W-1:0] inRegB;
  logic [REG_W-1:0]  inRegF_wreg;
  logic              outStall;
  logic              outPCSrc;
  logic [DATA_W-1:0] outPCBranch;
  logic [DATA_W-1:0] MEM_AluResult;
  logic [REG_W-1:0]  MEM_rd;
  logic              MEM_regF_wr;
  logic [1:0]        outWB;
  logic [DATA_W-1:0] outReadData;
  logic [DATA_W-1:0] outALUResult;
  logic [REG_W-1:0]  outRegF_wreg;
  logic              outMemErr;

  int   checks  = 0;
  int   errors  = 0;
  logic exp_err = 1'b0;

  mem_access_stage_if #(.DATA_W(DATA_W)) dmem_bus ();

  mem_access_stage #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inWB          (inWB),
    .inMEM         (inMEM),
    .inPCJump      (inPCJump),
    .inALUResult   (inALUResult),
    .inALUZero     (inALUZero),
    .inRegB        (inRegB),
    .inRegF_wreg   (inRegF_wreg),
    .dmem          (dmem_bus),
    .outStall      (outStall),
    .outPCSrc      (outPCSrc),
    .outPCBranch   (outPCBranch),
    .MEM_AluResult (MEM_AluResult),
    .MEM_rd        (MEM_rd),
    .MEM_regF_wr   (MEM_regF_wr),
    .outWB         (outWB),
    .outReadData   (outReadData),
    .outALUResult  (outALUResult),
    .outRegF_wreg  (outRegF_wreg),
    .outMemErr     (outMemErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One instruction from EX/MEM entry to write-back. Called just after a
  // falling edge with the stage idle; returns just after the edge that
  // writes its MEM/WB bundle. lat = WAIT cycle carrying ack (> TIMEOUT: none).
  task automatic run_instr(input logic [1:0] wb, input logic [2:0] mem,
                           input logic [31:0] alu, input logic [31:0] regb,
                           input logic [4:0] wreg, input logic zero,
                           input logic [31:0] pcj, input int lat,
                           input logic [31:0] rdata, input logic stray_ack);
    logic        is_mem, mis, is_wr, timed_out;
    logic [31:0] exp_rd;
    int          waits;
    is_mem    = mem[1] | mem[0];
    mis       = alu[1:0] != 2'b00;
    is_wr     = mem[0];
    timed_out = lat > int'(TIMEOUT);
    waits     = timed_out ? int'(TIMEOUT) : lat;
    exp_rd    = (is_wr || timed_out) ? 32'h0 : rdata;

    inWB = wb; inMEM = mem; inALUResult = alu; inRegB = regb;
    inRegF_wreg = wreg; inALUZero = zero; inPCJump = pcj;
    dmem_bus.ack = stray_ack;
    dmem_bus.rdata = $urandom;

    @(posedge clk);
    check("idle_stall", 32'(outStall), 32'(is_mem && !mis));
    check("idle_req", 32'(dmem_bus.req), 32'h0);
    check("pcsrc", 32'(outPCSrc), 32'(mem[2] & zero));
    check("pcbranch", outPCBranch, pcj);
    check("tap_alu", MEM_AluResult, alu);
    check("tap_rd", 32'(MEM_rd), 32'(wreg));
    check("tap_regwr", 32'(MEM_regF_wr), 32'(wb[1]));
    @(negedge clk); #1;
    dmem_bus.ack = 1'b0;

    if (!is_mem) begin
      check("alu_wb", 32'(outWB), 32'(wb));
      check("alu_res", outALUResult, alu);
      check("alu_rdata", outReadData, 32'h0);
      check("alu_wreg", 32'(outRegF_wreg), 32'(wreg));
      check("alu_err", 32'(outMemErr), 32'(exp_err));
      return;
    end
    if (mis) begin
      exp_err = 1'b1;
      check("mis_wb", 32'(outWB), 32'h0);
      check("mis_err", 32'(outMemErr), 32'h1);
      return;
    end

    check("issue_bubble", 32'(outWB), 32'h0);
    for (int c = 1; c <= waits; c++) begin
      dmem_bus.ack   = (c == lat);
      dmem_bus.rdata = (c == lat) ? rdata : $urandom;
      @(posedge clk);
      check("wait_stall", 32'(outStall), 32'h1);
      check("wait_req", 32'(dmem_bus.req), 32'h1);
      check("wait_we", 32'(dmem_bus.we), 32'(is_wr));
      check("wait_addr", dmem_bus.addr, alu);
      check("wait_wdata", dmem_bus.wdata, regb);
      @(negedge clk); #1;
      dmem_bus.ack = 1'b0;
      check("wait_bubble", 32'(outWB), 32'h0);
    end
    if (timed_out) exp_err = 1'b1;

    dmem_bus.rdata = $urandom;
    @(posedge clk);
    check("done_stall", 32'(outStall), 32'h0);
    check("done_req", 32'(dmem_bus.req), 32'h0);
    @(negedge clk); #1;
    check("wb_ctrl", 32'(outWB), 32'(wb));
    check("wb_rdata", outReadData, exp_rd);
    check("wb_alu", outALUResult, alu);
    check("wb_wreg", 32'(outRegF_wreg), 32'(wreg));
    check("wb_err", 32'(outMemErr), 32'(exp_err));
  endtask

  // Assert reset while a load is waiting for ack, then release.
  task automatic reset_mid_wait();
    inWB = 2'b11; inMEM = 3'b010; inALUResult = 32'h100; inRegB = 32'h0;
    inRegF_wreg = 5'd9; dmem_bus.ack = 1'b0;
    @(negedge clk); #1;
    @(posedge clk);
    check("rst_pre_req", 32'(dmem_bus.req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_req", 32'(dmem_bus.req), 32'h0);
    check("rst_we", 32'(dmem_bus.we), 32'h0);
    check("rst_wb", 32'(outWB), 32'h0);
    check("rst_rdata", outReadData, 32'h0);
    check("rst_alu", outALUResult, 32'h0);
    check("rst_wreg", 32'(outRegF_wreg), 32'h0);
    check("rst_err", 32'(outMemErr), 32'h0);
    exp_err = 1'b0;
    inMEM = 3'b000;
    #1;
    check("rst_idle_stall", 32'(outStall), 32'h0);
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [1:0]  r_wb;
    logic [2:0]  r_mem;
    logic [31:0] r_alu;
    logic [4:0]  r_wreg;
    rst = 1'b0;
    inWB = '0; inMEM = '0; inPCJump = '0; inALUResult = '0;
    inALUZero = 1'b0; inRegB = '0; inRegF_wreg = '0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    #1;
    check("init_req", 32'(dmem_bus.req), 32'h0);
    check("init_we", 32'(dmem_bus.we), 32'h0);
    check("init_wb", 32'(outWB), 32'h0);
    check("init_rdata", outReadData, 32'h0);
    check("init_alu", outALUResult, 32'h0);
    check("init_wreg", 32'(outRegF_wreg), 32'h0);
    check("init_err", 32'(outMemErr), 32'h0);
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk); #1;

    // Directed scenarios
    run_instr(2'b10, 3'b000, 32'h55, 32'h0, 5'd7, 1'b0, 32'h0, 0, 32'h0, 1'b1);
    run_instr(2'b11, 3'b010, 32'h10, 32'h0, 5'd3, 1'b0, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    run_instr(2'b00, 3'b001, 32'h20, 32'h1234, 5'd0, 1'b0, 32'h0, 1, 32'hCAFE0000, 1'b0);
    run_instr(2'b11, 3'b011, 32'h24, 32'h77, 5'd4, 1'b0, 32'h0, 2, 32'h11112222, 1'b0);
    run_instr(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h40, 0, 32'h0, 1'b0);
    run_instr(2'b00, 3'b100, 32'h4, 32'h0, 5'd0, 1'b0, 32'h40, 0, 32'h0, 1'b0);
    run_instr(2'b11, 3'b010, 32'h30, 32'h0, 5'd5, 1'b0, 32'h0, int'(TIMEOUT), 32'h0BADF00D, 1'b0);
    run_instr(2'b11, 3'b010, 32'h13, 32'h0, 5'd6, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    reset_mid_wait();
    run_instr(2'b11, 3'b010, 32'h44, 32'h0, 5'd8, 1'b0, 32'h0, int'(TIMEOUT) + 2, 32'h5A5A5A5A, 1'b0);
    reset_mid_wait();
    run_instr(2'b10, 3'b000, 32'h99, 32'h0, 5'd1, 1'b0, 32'h0, 0, 32'h0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 59) reset_mid_wait();
      r_wb   = 2'($urandom);
      r_wreg = 5'($urandom);
      r_alu  = $urandom;
      if ($urandom_range(0, 5) != 0) r_alu[1:0] = 2'b00;
      case ($urandom_range(0, 3))
        0:       r_mem = {1'($urandom), 2'b00};
        1:       r_mem = 3'b010;
        2:       r_mem = 3'b001;
        default: r_mem = 3'b011;
      endcase
      run_instr(r_wb, r_mem, r_alu, $urandom, r_wreg, 1'($urandom), $urandom,
                $urandom_range(1, TIMEOUT + 2), $urandom, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
